// File: rtl/opamp_share_arb_if.sv
// rtl/opamp_share_arb_if.sv - request/switch/grant bundle between requesters and the opamp share arbiter
interface opamp_share_arb_if #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 8
);
  logic [N_REQ-1:0] req;
  logic [CNT_W-1:0] settle_cycles;
  logic [CNT_W-1:0] hold_cycles;
  logic [N_REQ-1:0] sw_en;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] done;
  logic             amp_en;
  logic             busy;
  logic             az_en;

  // Requester side: drives requests and timing, observes switches and grants
  modport master (
    output req, settle_cycles, hold_cycles,
    input  sw_en, gnt, done, amp_en, busy, az_en
  );

  // Arbiter side
  modport slave (
    input  req, settle_cycles, hold_cycles,
    output sw_en, gnt, done, amp_en, busy, az_en
  );
endinterface

// File: rtl/opamp_share_arb.sv
// rtl/opamp_share_arb.sv - round-robin time-sharing of one opamp with break-before-make switching (optional auto-zero: OPAMP_SHARE_AUTOZERO_EN)
module opamp_share_arb #(
  parameter int N_REQ       = 4,
  parameter int CNT_W       = 8,
  parameter int DEAD_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  opamp_share_arb_if.slave   bus
);

  localparam int SEL_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW    = (CNT_W > 4) ? CNT_W : 4;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
`ifdef OPAMP_SHARE_AUTOZERO_EN
  localparam logic [CW-1:0] AZ_LAST = CW'(3);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
`ifdef OPAMP_SHARE_AUTOZERO_EN
    ST_AZ,
`endif
    ST_SETTLE,
    ST_GRANT
  } state_t;

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [SEL_W-1:0] r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [CNT_W-1:0] r_settle;
  logic [CNT_W-1:0] r_hold;
  logic [N_REQ-1:0] r_sw_en;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_amp_en;
  logic             r_busy;

  state_t           w_nxt_state;
  logic [SEL_W-1:0] w_nxt_sel;
  logic [SEL_W-1:0] w_nxt_ptr;
  logic [CW-1:0]    w_nxt_cnt;
  logic [N_REQ-1:0] w_nxt_done;
  logic [N_REQ-1:0] w_nxt_oh;
  logic [N_REQ-1:0] w_sel_oh;
  logic             w_ptr_found;
  logic [SEL_W-1:0] w_ptr_idx;
  logic             w_sel_found;
  logic [SEL_W-1:0] w_sel_idx;
  logic [CW-1:0]    w_settle_last;
  logic [CW-1:0]    w_hold_last;
  logic             w_hold_expired;

  // First set request bit searching upward from base+1 with wrap; base itself is checked last
  function automatic logic [SEL_W:0] rr_pick(input logic [N_REQ-1:0] req_v,
                                             input logic [SEL_W-1:0] base);
    logic             found;
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] pos;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = SEL_W'((int'(base) + k) % N_REQ);
      if (!found && req_v[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
    return {found, idx};
  endfunction

  // Fresh pick from the last completed grant, and a rotation pick used when a grant completes
  assign {w_ptr_found, w_ptr_idx} = rr_pick(bus.req, r_ptr);
  assign {w_sel_found, w_sel_idx} = rr_pick(bus.req, r_sel);

  assign w_sel_oh       = N_REQ'(1) << r_sel;
  assign w_nxt_oh       = N_REQ'(1) << w_nxt_sel;
  assign w_settle_last  = CW'(r_settle - 1'b1);
  assign w_hold_last    = CW'(r_hold - 1'b1);
  assign w_hold_expired = (r_hold != '0) && (r_cnt == w_hold_last);

  // Next-state, selection, pointer, counter and completion pulse
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_sel   = r_sel;
    w_nxt_ptr   = r_ptr;
    w_nxt_cnt   = r_cnt;
    w_nxt_done  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_ptr_found) begin
          w_nxt_state = ST_DEAD;
          w_nxt_sel   = w_ptr_idx;
          w_nxt_cnt   = '0;
        end
      end
      ST_DEAD: begin
        if (!bus.req[r_sel]) begin
          w_nxt_state = w_ptr_found ? ST_DEAD : ST_IDLE;
          w_nxt_sel   = w_ptr_found ? w_ptr_idx : r_sel;
          w_nxt_cnt   = '0;
        end else if (r_cnt == DEAD_LAST) begin
`ifdef OPAMP_SHARE_AUTOZERO_EN
          w_nxt_state = ST_AZ;
`else
          w_nxt_state = ST_SETTLE;
`endif
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
`ifdef OPAMP_SHARE_AUTOZERO_EN
      ST_AZ: begin
        if (!bus.req[r_sel]) begin
          w_nxt_state = w_ptr_found ? ST_DEAD : ST_IDLE;
          w_nxt_sel   = w_ptr_found ? w_ptr_idx : r_sel;
          w_nxt_cnt   = '0;
        end else if (r_cnt == AZ_LAST) begin
          w_nxt_state = ST_SETTLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
`endif
      ST_SETTLE: begin
        if (!bus.req[r_sel]) begin
          w_nxt_state = w_ptr_found ? ST_DEAD : ST_IDLE;
          w_nxt_sel   = w_ptr_found ? w_ptr_idx : r_sel;
          w_nxt_cnt   = '0;
        end else if (r_cnt == w_settle_last) begin
          w_nxt_state = ST_GRANT;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      ST_GRANT: begin
        if (!bus.req[r_sel] || w_hold_expired) begin
          w_nxt_done  = w_sel_oh;
          w_nxt_ptr   = r_sel;
          w_nxt_state = w_sel_found ? ST_DEAD : ST_IDLE;
          w_nxt_sel   = w_sel_found ? w_sel_idx : r_sel;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // State, counters and captured timing; timing is latched only on SETTLE entry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_sel    <= '0;
      r_ptr    <= SEL_W'(N_REQ - 1);
      r_cnt    <= '0;
      r_settle <= '0;
      r_hold   <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_sel   <= w_nxt_sel;
      r_ptr   <= w_nxt_ptr;
      r_cnt   <= w_nxt_cnt;
      if (r_state != ST_SETTLE && w_nxt_state == ST_SETTLE) begin
        r_settle <= (bus.settle_cycles == '0) ? CNT_W'(1) : bus.settle_cycles;
        r_hold   <= bus.hold_cycles;
      end
    end
  end

  // Outputs registered from the next state so they align with the state they describe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sw_en  <= '0;
      r_gnt    <= '0;
      r_done   <= '0;
      r_amp_en <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_sw_en  <= (w_nxt_state == ST_SETTLE || w_nxt_state == ST_GRANT) ? w_nxt_oh : '0;
      r_gnt    <= (w_nxt_state == ST_GRANT) ? w_nxt_oh : '0;
      r_done   <= w_nxt_done;
      r_amp_en <= (w_nxt_state != ST_IDLE);
      r_busy   <= (w_nxt_state != ST_IDLE);
    end
  end

`ifdef OPAMP_SHARE_AUTOZERO_EN
  logic r_az_en;

  // Auto-zero switch closed only while in AZ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_az_en <= 1'b0;
    else     r_az_en <= (w_nxt_state == ST_AZ);
  end

  assign bus.az_en = r_az_en;
`else
  assign bus.az_en = 1'b0;
`endif

  assign bus.sw_en  = r_sw_en;
  assign bus.gnt    = r_gnt;
  assign bus.done   = r_done;
  assign bus.amp_en = r_amp_en;
  assign bus.busy   = r_busy;

endmodule
